toggle_handshake_receiver: RTL and testbench
============================================

Name: toggle_handshake_receiver

Overview:
Receiving end of a two-phase toggle handshake. The sender flips a single request line (REQ_T) once per transfer, the same way a T flip-flop changes state, and holds DATA stable until acknowledged. This block synchronises REQ_T and detects each flip. It captures DATA, presents it to the local consumer with a VALID/READY handshake, and returns an acknowledge toggle (ACK_T) to the sender. It sits at a clock-domain or module boundary opposite a toggle-based transmitter.

Parameters:
DATA_W, 8, width of transferred data word
SYNC_STAGES, 2, flops in REQ_T synchroniser chain (legal range 2..4)
CNT_W, 8, width of transfer counter

Ports:
CLK  input  1  rising-edge clock; all state changes on this edge
RSTn  input  1  synchronous active-low reset, sampled on rising edge of CLK
REQ_T  input  1  request toggle from sender; each level change = one transfer
DATA  input  DATA_W  sender data; stable from before REQ_T flips until ACK_T flips
ACK_T  output  1  acknowledge toggle to sender; flips once per consumed transfer
DOUT  output  DATA_W  captured data word
VALID  output  1  DOUT holds an unconsumed word
READY  input  1  consumer accepts DOUT when VALID=1
COUNT  output  CNT_W  number of completed transfers, modulo 2^CNT_W
ERR  output  1  sticky protocol-violation flag

Behaviour:
- Reset (RSTn=0 at a rising edge):
  - synchroniser chain, req_seen, ACK_T, VALID, DOUT, COUNT and ERR all go to 0.
  - State goes to IDLE.
  - Reset mid-transfer discards any held word; no ACK_T is issued for it.
  - The sender must also be reset so that REQ_T returns to 0.
- Synchroniser: REQ_T passes through SYNC_STAGES flops; req_s is the last stage.
- Toggle detect: tgl = req_s XOR req_seen. req_seen <= req_s every non-reset cycle, so each flip yields exactly one tgl cycle.
- IDLE, VALID=0:
  - On an edge where tgl=1: DOUT <= DATA, VALID <= 1, go to HOLD.
  - Latency: REQ_T flips before edge k; tgl=1 during the cycle after edge k+SYNC_STAGES-1; VALID=1 after edge k+SYNC_STAGES.
- HOLD, VALID=1:
  - DOUT is stable.
  - On an edge where READY=1: VALID <= 0, ACK_T <= ~ACK_T, COUNT <= COUNT+1 (wraps from all-ones to 0), go to IDLE.
  - READY is ignored in IDLE. VALID is high for at least one cycle.
- Overrun: tgl=1 while in HOLD is a protocol violation.
  - ERR <= 1 (sticky until reset).
  - New DATA is discarded; DOUT and VALID are unchanged; no extra ACK_T.
  - req_seen still updates, so the flip is not re-detected.
- tgl=1 and READY=1 on the same edge in HOLD: the consume completes normally and ERR is still set. The new word is not captured.
- Back-to-back transfers: the next REQ_T flip is legal immediately after ACK_T flips. The sender's own synchronisation delay guarantees there is no overlap.
- ACK_T, VALID, COUNT and ERR are registered outputs; there are no combinational input-to-output paths.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=1'b0, HOLD=1'b1;
  - default DATA_W, SYNC_STAGES and CNT_W constants shared with the matching transmitter.
- One sub-module: toggle_sync_detect. It contains the SYNC_STAGES synchroniser plus the req_seen register and outputs the one-cycle tgl pulse. It is reusable by the transmitter to detect ACK_T.
- The top level contains the FSM, data register, counter and ERR.

Test Plan:
- Reset: hold RSTn=0 for 2 edges with REQ_T=1 and READY=1 -> ACK_T=0, VALID=0, DOUT=0, COUNT=0, ERR=0. A release with REQ_T=0 then produces no VALID.
- Single transfer, SYNC_STAGES=2: DATA=8'hA5, REQ_T flips 0->1 before edge k, READY=1 -> VALID=1 after edge k+2 with DOUT=8'hA5. After edge k+3: VALID=0, ACK_T=1, COUNT=1.
- Consumer stall: READY=0 for 5 cycles after VALID -> VALID and DOUT=8'h3C held, ACK_T unchanged. Raising READY gives one ACK_T flip, and COUNT increments by 1.
- Back-to-back: 4 transfers (8'h01..8'h04) with REQ_T flipped as soon as ACK_T changes -> DOUT sequence 01,02,03,04; ACK_T ends at 0; COUNT=4; ERR=0.
- Overrun: flip REQ_T twice without the consumer asserting READY -> ERR=1 after the second detection, DOUT keeps the first word, and ACK_T flips once on the eventual READY. ERR stays 1 until RSTn=0.
- Wrap and reset mid-HOLD: with CNT_W=2 and 5 transfers -> COUNT=1. Then capture a word, assert RSTn=0 while VALID=1 -> VALID=0, ACK_T=0, COUNT=0 after that edge.

Source files
------------

// File: rtl/toggle_handshake_receiver_pkg.sv
// Shared constants and state encoding for the toggle handshake pair.
// Defaults are common to the receiver and the matching transmitter.
package toggle_handshake_receiver_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/toggle_handshake_receiver_sync_detect.sv
// Toggle synchroniser and edge detector: one-cycle pulse per level change.
// Reused on the transmitter side to detect ACK_T flips.
module toggle_sync_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tog,
  output logic o_tgl
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_seen;
  logic                   w_req_s;

  assign w_req_s = r_sync[SYNC_STAGES-1];
  assign o_tgl   = w_req_s ^ r_seen;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_seen <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_tog};
      r_seen <= w_req_s;
    end
  end

endmodule

// File: rtl/toggle_handshake_receiver.sv
// Receiving end of a two-phase toggle handshake with VALID/READY output.
// Overruns are dropped and flagged in a sticky ERR bit.
module toggle_handshake_receiver
  import toggle_handshake_receiver_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              REQ_T,
  input  logic [DATA_W-1:0] DATA,
  output logic              ACK_T,
  output logic [DATA_W-1:0] DOUT,
  output logic              VALID,
  input  logic              READY,
  output logic [CNT_W-1:0]  COUNT,
  output logic              ERR
);

  state_e r_state;
  state_e w_state_nxt;
  logic   w_tgl;
  logic   w_capture;
  logic   w_consume;
  logic   w_overrun;

  toggle_sync_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (CLK),
    .i_rst_n (RSTn),
    .i_tog   (REQ_T),
    .o_tgl   (w_tgl)
  );

  assign VALID = (r_state == HOLD);

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_consume   = 1'b0;
    w_overrun   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_tgl) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // A flip while holding is dropped; READY still completes the word
        w_overrun = w_tgl;
        if (READY) begin
          w_consume   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state <= IDLE;
      ACK_T   <= 1'b0;
      DOUT    <= '0;
      COUNT   <= '0;
      ERR     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) DOUT <= DATA;
      if (w_consume) begin
        ACK_T <= ~ACK_T;
        COUNT <= COUNT + CNT_W'(1);
      end
      if (w_overrun) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_toggle_handshake_receiver.sv
// Scoreboard bench: sender pushes expected words, monitor pops on consume.
// A second instance with a 2-bit counter exercises wrap-around.
module tb_toggle_handshake_receiver;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       REQ_T;
  logic [7:0] DATA;
  logic       READY;

  logic       ACK_T, VALID, ERR;
  logic [7:0] DOUT, COUNT;
  logic       ack_w, valid_w, err_w;
  logic [7:0] dout_w;
  logic [1:0] count_w;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  int         m_count = 0;
  logic       m_ack   = 1'b0;
  logic       exp_err = 1'b0;

  always #5 CLK = ~CLK;

  toggle_handshake_receiver dut (
    .CLK(CLK), .RSTn(RSTn), .REQ_T(REQ_T), .DATA(DATA),
    .ACK_T(ACK_T), .DOUT(DOUT), .VALID(VALID), .READY(READY),
    .COUNT(COUNT), .ERR(ERR)
  );

  toggle_handshake_receiver #(.CNT_W(2)) dut_w (
    .CLK(CLK), .RSTn(RSTn), .REQ_T(REQ_T), .DATA(DATA),
    .ACK_T(ack_w), .DOUT(dout_w), .VALID(valid_w), .READY(READY),
    .COUNT(count_w), .ERR(err_w)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every consume must match the oldest outstanding word
  always @(negedge CLK) begin
    if (RSTn === 1'b1 && VALID === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_valid", 32'(VALID), 32'd0);
      end else if (READY === 1'b1) begin
        check("dout", 32'(DOUT), 32'(q[0]));
        check("count", 32'(COUNT), 32'(m_count % 256));
        check("count_w", 32'(count_w), 32'(m_count % 4));
        check("ack", 32'(ACK_T), 32'(m_ack));
        check("err", 32'(ERR), 32'(exp_err));
        void'(q.pop_front());
        m_count++;
        m_ack = ~m_ack;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTn  = 1'b0;
    REQ_T = 1'b0;
    READY = 1'b0;
    step();
    step();
    RSTn = 1'b1;
    q.delete();
    m_count = 0;
    m_ack   = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    while (ACK_T !== REQ_T && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) check("send_timeout", 32'd1, 32'd0);
    DATA  = d;
    REQ_T = ~REQ_T;
    q.push_back(d);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (VALID !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check(nm, 32'(VALID), 32'd1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    READY = 1'b1;
    while ((q.size() != 0 || VALID !== 1'b0) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check(nm, 32'(q.size()), 32'd0);
  endtask

  initial begin
    DATA = 8'h00;
    // Reset with REQ_T and READY high
    RSTn  = 1'b0;
    REQ_T = 1'b1;
    READY = 1'b1;
    step();
    step();
    check("rst_ack", 32'(ACK_T), 32'd0);
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_dout", 32'(DOUT), 32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    REQ_T = 1'b0;
    RSTn  = 1'b1;
    repeat (6) step();
    check("post_rst_valid", 32'(VALID), 32'd0);

    // Single transfer latency with SYNC_STAGES=2
    READY = 1'b1;
    send(8'hA5);
    step();
    check("lat_k", 32'(VALID), 32'd0);
    step();
    check("lat_k1", 32'(VALID), 32'd0);
    step();
    check("lat_k2_valid", 32'(VALID), 32'd1);
    check("lat_k2_dout", 32'(DOUT), 32'hA5);
    step();
    check("lat_k3_valid", 32'(VALID), 32'd0);
    check("lat_k3_ack", 32'(ACK_T), 32'd1);
    check("lat_k3_count", 32'(COUNT), 32'd1);

    // Consumer stall
    READY = 1'b0;
    send(8'h3C);
    wait_valid("stall_timeout");
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 32'(VALID), 32'd1);
      check("stall_dout", 32'(DOUT), 32'h3C);
      check("stall_ack", 32'(ACK_T), 32'd1);
    end
    READY = 1'b1;
    step();
    check("stall_ack_flip", 32'(ACK_T), 32'd0);
    check("stall_count", 32'(COUNT), 32'd2);

    // Back-to-back from reset
    do_reset();
    READY = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(i));
    drain("b2b_drain");
    check("b2b_ack", 32'(ACK_T), 32'd0);
    check("b2b_count", 32'(COUNT), 32'd4);
    check("b2b_err", 32'(ERR), 32'd0);

    // Overrun
    do_reset();
    send(8'h11);
    wait_valid("ovr_timeout");
    DATA  = 8'h22;
    REQ_T = ~REQ_T;
    repeat (4) step();
    exp_err = 1'b1;
    check("ovr_err", 32'(ERR), 32'd1);
    check("ovr_dout", 32'(DOUT), 32'h11);
    check("ovr_ack", 32'(ACK_T), 32'd0);
    READY = 1'b1;
    step();
    repeat (5) step();
    check("ovr_ack_once", 32'(ACK_T), 32'd1);
    check("ovr_no_recap", 32'(VALID), 32'd0);
    check("ovr_sticky", 32'(ERR), 32'd1);
    do_reset();
    check("ovr_err_clr", 32'(ERR), 32'd0);

    // Counter wrap then reset while holding
    READY = 1'b1;
    for (int i = 0; i < 5; i++) send(8'($urandom));
    drain("wrap_drain");
    check("wrap_count_w", 32'(count_w), 32'd1);
    check("wrap_count", 32'(COUNT), 32'd5);
    READY = 1'b0;
    send(8'h5A);
    wait_valid("hold_timeout");
    RSTn = 1'b0;
    step();
    q.delete();
    check("midhold_valid", 32'(VALID), 32'd0);
    check("midhold_ack", 32'(ACK_T), 32'd0);
    check("midhold_count", 32'(COUNT), 32'd0);
    REQ_T = 1'b0;
    step();
    RSTn    = 1'b1;
    m_count = 0;
    m_ack   = 1'b0;
    exp_err = 1'b0;

    // Randomised traffic with random consumer stalls
    for (int c = 0; c < 400; c++) begin
      READY = 1'($urandom_range(0, 1));
      if (ACK_T === REQ_T && $urandom_range(0, 1) == 1) begin
        DATA  = 8'($urandom);
        REQ_T = ~REQ_T;
        q.push_back(DATA);
      end
      step();
    end
    drain("rand_drain");
    repeat (4) step();
    check("rand_count", 32'(COUNT), 32'(m_count % 256));
    check("rand_count_w", 32'(count_w), 32'(m_count % 4));
    check("rand_err", 32'(ERR), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
